// File: rtl/seed_ram_ctrl_pkg.sv
// Shared constants and FSM encoding for the seed vector RAM controller.
package seed_ram_ctrl_pkg;

  localparam int seed_ram_aw     = 10;
  localparam int seed_ram_dw_bit = 5;
  localparam int seed_ram_dw     = 1 << seed_ram_dw_bit;
  localparam int seed_ram_waw    = seed_ram_aw - seed_ram_dw_bit;
  localparam int seed_ram_words  = 1 << seed_ram_waw;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_SET_RD  = 3'd2,
    S_SET_WR  = 3'd3,
    S_TST_RD  = 3'd4,
    S_TST_RSP = 3'd5
  } seed_state_e;

endpackage

// File: rtl/seed_rr_arb2.sv
// Two-way round-robin arbiter; index 0 is the set requester, index 1 the test requester.
module seed_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rrPtr_q;

  // Contention goes to the side the pointer favours, a lone request always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rrPtr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant is taken, favour the other requester next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      rrPtr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/seed_ram_ctrl.sv
// Serialising sequencer for the single-port seed vector RAM: clear sweep, bit-set RMW, bit-test.
module seed_ram_ctrl
  import seed_ram_ctrl_pkg::*;
#(
  parameter  int AW     = seed_ram_aw,
  parameter  int DW_BIT = seed_ram_dw_bit,
  localparam int DW     = 1 << DW_BIT,
  localparam int WAW    = AW - DW_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic           clr_done,
  input  logic           set_req,
  input  logic [31:0]    set_addr,
  output logic           set_ack,
  input  logic           tst_req,
  input  logic [31:0]    tst_addr,
  output logic           tst_ack,
  output logic           tst_hit,
  output logic           ram_ce,
  output logic           ram_we,
  output logic [WAW-1:0] ram_addr,
  output logic [DW-1:0]  ram_di,
  input  logic [DW-1:0]  ram_doq
);

  seed_state_e       state_q;
  logic              clrPend_q;
  logic [WAW-1:0]    cnt_q;
  logic [WAW-1:0]    wordAddr_q;
  logic [DW_BIT-1:0] bitIdx_q;

  logic [1:0]        gnt;
  logic              advance;
  logic [DW-1:0]     bitMask;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{set_addr[31:AW], tst_addr[31:AW]};

  // The arbiter pointer only moves when IDLE actually hands out a request grant.
  assign advance = (state_q == S_IDLE) && !clrPend_q;
  assign bitMask = DW'(1) << bitIdx_q;

  seed_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({tst_req, set_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Sequencer: a pending clear wins in IDLE, otherwise the arbiter grant picks set or test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clrPend_q  <= 1'b0;
      cnt_q      <= '0;
      wordAddr_q <= '0;
      bitIdx_q   <= '0;
    end else begin
      if (clr_start && (state_q != S_CLR)) begin
        clrPend_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (clrPend_q) begin
            state_q   <= S_CLR;
            cnt_q     <= '0;
            clrPend_q <= 1'b0;
          end else if (gnt[0]) begin
            state_q    <= S_SET_RD;
            wordAddr_q <= set_addr[AW-1:DW_BIT];
            bitIdx_q   <= set_addr[DW_BIT-1:0];
          end else if (gnt[1]) begin
            state_q    <= S_TST_RD;
            wordAddr_q <= tst_addr[AW-1:DW_BIT];
            bitIdx_q   <= tst_addr[DW_BIT-1:0];
          end
        end
        S_SET_RD:  state_q <= S_SET_WR;
        S_SET_WR:  state_q <= S_IDLE;
        S_TST_RD:  state_q <= S_TST_RSP;
        S_TST_RSP: state_q <= S_IDLE;
        S_CLR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM strobes and handshakes depend only on flopped state plus the RAM read data.
  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    set_ack  = 1'b0;
    tst_ack  = 1'b0;
    tst_hit  = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      S_CLR: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        clr_done = (cnt_q == '1);
      end
      S_SET_RD: begin
        ram_ce   = 1'b1;
        ram_addr = wordAddr_q;
      end
      S_SET_WR: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = wordAddr_q;
        ram_di   = ram_doq | bitMask;
        set_ack  = 1'b1;
      end
      S_TST_RD: begin
        ram_ce   = 1'b1;
        ram_addr = wordAddr_q;
      end
      S_TST_RSP: begin
        tst_ack = 1'b1;
        tst_hit = ram_doq[bitIdx_q];
      end
      default: ;
    endcase
  end

  assign clr_busy = clrPend_q | (state_q == S_CLR);

endmodule
